multi_alu: RTL and testbench

MULTI_ALU -- requirements
Module: multi_alu

---
 rtl/multi_alu_if.sv | 22 ++
 rtl/multi_alu.sv | 198 +++++++++++++++++++
 tb/tb_multi_alu.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_alu_if.sv
// rtl/multi_alu_if.sv - E-stage to M-extension ALU handshake bundle
interface multi_alu_if;
  logic        valid;
  logic [2:0]  op;
  logic        word;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        e_wait;
  logic        done;
  logic [63:0] result;

  modport master (
    output valid, op, word, a, b, flush,
    input  e_wait, done, result
  );

  modport slave (
    input  valid, op, word, a, b, flush,
    output e_wait, done, result
  );
endinterface

// File: rtl/multi_alu.sv
// rtl/multi_alu.sv - iterative RV64M multiply/divide unit (MULTI_ALU_FAST_MUL_EN selects single-cycle multiply)
module multi_alu (
  input  logic       clk,
  input  logic       resetn,
  multi_alu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [2:0]   op_q, op_d;
  logic         word_q, word_d;
  logic         neg_q, neg_d;
  logic         rneg_q, rneg_d;
  logic [127:0] acc_q, acc_d;
  logic [127:0] sh_q, sh_d;
  logic [63:0]  mp_q, mp_d;
  logic [63:0]  result_q, result_d;

  // acc: product accumulator / partial remainder (low half)
  // sh : shifting multiplicand / divisor (low half)
  // mp : multiplier shifting out right / dividend shifting out left, quotient shifting in

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] pick_mul(input logic [127:0] p, input logic [2:0] op, input logic w);
    if (op == 3'd0) return w ? sext32(p[31:0]) : p[63:0];
    return p[127:64];
  endfunction

  logic        sgn_a, sgn_b, neg_a, neg_b;
  logic [63:0] a_ext, b_ext, mag_a, mag_b;
  logic        div_zero, div_ovf;
  logic [63:0] special_res;

  // Decode the incoming op: operand extension, magnitudes and the division corner cases
  always_comb begin
    sgn_a = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op[2] && !bus.op[0]);
    sgn_b = (bus.op == 3'd1) || (bus.op[2] && !bus.op[0]);
    if (bus.word) begin
      a_ext = sgn_a ? sext32(bus.a[31:0]) : {32'b0, bus.a[31:0]};
      b_ext = sgn_b ? sext32(bus.b[31:0]) : {32'b0, bus.b[31:0]};
    end else begin
      a_ext = bus.a;
      b_ext = bus.b;
    end
    neg_a = sgn_a & a_ext[63];
    neg_b = sgn_b & b_ext[63];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
    div_zero = bus.op[2] && (b_ext == 64'd0);
    div_ovf  = bus.op[2] && !bus.op[0] && (b_ext == {64{1'b1}}) &&
               (a_ext == (bus.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special_res = 64'd0;
    if (div_zero)
      special_res = bus.op[1] ? (bus.word ? sext32(bus.a[31:0]) : bus.a) : {64{1'b1}};
    else if (div_ovf)
      special_res = bus.op[1] ? 64'd0 : (bus.word ? sext32(bus.a[31:0]) : bus.a);
  end

`ifdef MULTI_ALU_FAST_MUL_EN
  logic [127:0] fast_mag, fast_prod;
  assign fast_mag  = {64'b0, mag_a} * {64'b0, mag_b};
  assign fast_prod = (neg_a ^ neg_b) ? -fast_mag : fast_mag;
`endif

  logic [127:0] acc_mul, mul_prod, acc_div;
  logic [64:0]  rem_try;
  logic         rem_ge;
  logic [63:0]  rem_diff, mp_div, quo, quo_s, rem, rem_s, div_pick;
  logic [63:0]  mul_res, div_res;

  // One iteration of shift-add multiply and restoring divide, plus final sign fix-up
  always_comb begin
    acc_mul  = mp_q[0] ? (acc_q + sh_q) : acc_q;
    mul_prod = neg_q ? -acc_mul : acc_mul;
    mul_res  = pick_mul(mul_prod, op_q, word_q);

    rem_try  = {acc_q[63:0], mp_q[63]};
    rem_ge   = rem_try >= {1'b0, sh_q[63:0]};
    rem_diff = rem_try[63:0] - sh_q[63:0];
    acc_div  = {64'b0, rem_ge ? rem_diff : rem_try[63:0]};
    mp_div   = {mp_q[62:0], rem_ge};

    quo      = word_q ? {32'b0, mp_div[31:0]} : mp_div;
    quo_s    = neg_q ? -quo : quo;
    rem      = acc_div[63:0];
    rem_s    = rneg_q ? -rem : rem;
    div_pick = op_q[1] ? rem_s : quo_s;
    div_res  = word_q ? sext32(div_pick[31:0]) : div_pick;
  end

  // Next-state and datapath control; flush overrides everything and drops the result
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    mp_d     = mp_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          op_d   = bus.op;
          word_d = bus.word;
          neg_d  = neg_a ^ neg_b;
          rneg_d = neg_a;
          cnt_d  = bus.word ? 6'd31 : 6'd63;
          acc_d  = 128'd0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else if (!bus.op[2]) begin
`ifdef MULTI_ALU_FAST_MUL_EN
            result_d = pick_mul(fast_prod, bus.op, bus.word);
            state_d  = S_DONE;
`else
            sh_d    = {64'b0, mag_a};
            mp_d    = mag_b;
            state_d = S_MUL;
`endif
          end else begin
            sh_d    = {64'b0, mag_b};
            mp_d    = bus.word ? {mag_a[31:0], 32'b0} : mag_a;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_mul;
        sh_d  = {sh_q[126:0], 1'b0};
        mp_d  = {1'b0, mp_q[63:1]};
        if (cnt_q == 6'd0) begin
          result_d = mul_res;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DIV: begin
        acc_d = acc_div;
        mp_d  = mp_div;
        if (cnt_q == 6'd0) begin
          result_d = div_res;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers; reset abandons any in-flight op
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= 128'd0;
      sh_q     <= 128'd0;
      mp_q     <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      mp_q     <= mp_d;
      result_q <= result_d;
    end
  end

  assign bus.e_wait = resetn & bus.valid & (state_q != S_DONE) & ~bus.flush;
  assign bus.done   = resetn & (state_q == S_DONE) & ~bus.flush;
  assign bus.result = result_q;

endmodule

// File: tb/tb_multi_alu.sv
// tb/tb_multi_alu.sv - randomized self-checking bench for multi_alu
module tb_multi_alu;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [63:0] obs_res;

  multi_alu_if alu_if();

  multi_alu dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (alu_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RV64M semantics computed directly from the ISA rules
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [31:0]  a32, b32, r32;
    logic [127:0] p;
    logic [63:0]  r;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      case (op)
        3'd0: r32 = a32 * b32;
        3'd4: if (b32 == 0) r32 = '1;
              else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
              else r32 = $signed(a32) / $signed(b32);
        3'd5: r32 = (b32 == 0) ? '1 : a32 / b32;
        3'd6: if (b32 == 0) r32 = a32;
              else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 0;
              else r32 = $signed(a32) % $signed(b32);
        3'd7: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = 0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    p = 0;
    case (op)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; r = p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
      3'd4: if (b == 0) r = '1;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
            else r = $signed(a) / $signed(b);
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 0;
            else r = $signed(a) % $signed(b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_cycles(input logic [2:0] op, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (op[2] && (zero || ovf)) return 1;
`ifdef MULTI_ALU_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Drive one op and follow it to its done pulse; leaves inputs held so a next op can go back-to-back
  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input string tag);
    int cyc;
    bit seen;
    alu_if.valid = 1'b1;
    alu_if.op    = op;
    alu_if.word  = w;
    alu_if.a     = a;
    alu_if.b     = b;
    alu_if.flush = 1'b0;
    cyc  = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      #1;
      if (alu_if.done) begin
        seen    = 1;
        obs_res = alu_if.result;
        check({tag, " e_wait_in_done"}, 64'(alu_if.e_wait), 64'd0);
        check({tag, " result"}, alu_if.result, ref_result(op, w, a, b));
        check({tag, " e_wait_cycles"}, 64'(cyc), 64'(exp_cycles(op, w, a, b)));
      end else begin
        if (alu_if.e_wait) cyc++;
        @(negedge clk);
      end
    end
    if (!seen) check({tag, " timeout"}, 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int dcount;
    logic [2:0]  rop;
    logic        rw;
    checks = 0;
    errors = 0;
    obs_res = 0;
    clk = 0;
    resetn = 0;
    alu_if.valid = 0;
    alu_if.op    = 0;
    alu_if.word  = 0;
    alu_if.a     = 0;
    alu_if.b     = 0;
    alu_if.flush = 0;

    repeat (2) @(negedge clk);
    alu_if.valid = 1'b1;
    #1;
    check("reset e_wait", 64'(alu_if.e_wait), 64'd0);
    check("reset done", 64'(alu_if.done), 64'd0);
    check("reset result", alu_if.result, 64'd0);
    @(negedge clk);
    alu_if.valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    run_op(3'd0, 1'b0, 64'd7, -64'd3, "mul_7_m3");
    check("mul_7_m3 const", obs_res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, "divw_ovf");
    check("divw_ovf const", obs_res, 64'hFFFF_FFFF_8000_0000);
    run_op(3'd6, 1'b1, 64'h0000_0000_8000_0000, '1, "remw_ovf");
    check("remw_ovf const", obs_res, 64'd0);
    run_op(3'd5, 1'b0, 64'd100, 64'd0, "divu_zero");
    check("divu_zero const", obs_res, '1);
    run_op(3'd7, 1'b0, 64'd100, 64'd0, "remu_zero");
    check("remu_zero const", obs_res, 64'd100);
    run_op(3'd6, 1'b0, -64'd7, 64'd2, "rem_m7_2");
    check("rem_m7_2 const", obs_res, '1);
    run_op(3'd4, 1'b0, -64'd7, 64'd2, "div_m7_2");
    check("div_m7_2 const", obs_res, -64'd3);
    run_op(3'd3, 1'b0, '1, '1, "mulhu_ones");
    check("mulhu_ones const", obs_res, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(3'd0, 1'b1, 64'd3, 64'd5, "mulw_3_5");
    check("mulw_3_5 const", obs_res, 64'd15);

    alu_if.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("hold done", 64'(alu_if.done), 64'd0);
      check("hold result", alu_if.result, obs_res);
    end
    @(negedge clk);

    alu_if.valid = 1'b1;
    alu_if.op    = 3'd4;
    alu_if.word  = 1'b0;
    alu_if.a     = 64'd987654321;
    alu_if.b     = 64'd12345;
    repeat (10) @(negedge clk);
    alu_if.flush = 1'b1;
    #1;
    check("flush e_wait", 64'(alu_if.e_wait), 64'd0);
    check("flush done", 64'(alu_if.done), 64'd0);
    @(negedge clk);
    run_op(3'd5, 1'b0, 64'd9, 64'd2, "divu_after_flush");
    check("divu_after_flush const", obs_res, 64'd4);

    alu_if.op = 3'd0;
    alu_if.a  = 64'h1234_5678_9ABC_DEF0;
    alu_if.b  = 64'h0FED_CBA9_8765_4321;
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset e_wait", 64'(alu_if.e_wait), 64'd0);
    check("midreset done", 64'(alu_if.done), 64'd0);
    check("midreset result", alu_if.result, 64'd0);
    @(negedge clk);
    alu_if.valid = 1'b0;
    resetn = 1'b1;
    dcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (alu_if.done) dcount++;
    end
    check("no done after reset", 64'(dcount), 64'd0);
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = (rop == 3'd0 || rop[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(rop, rw, pick_operand(), pick_operand(), $sformatf("rand%0d op%0d w%0d", n, rop, rw));
    end

    alu_if.valid = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
